// File: rtl/instr_decode_pkg.sv
// Shared types, default configuration and opcode helpers for the sequenced instruction decoder.
package instr_decode_pkg;

    localparam int unsigned OPCODE_W_DEF  = 4;
    localparam int unsigned CTRL_W_DEF    = 14;
    localparam logic [15:0] MC_MASK_DEF   = 16'h0300;
    localparam int unsigned MC_CYCLES_DEF = 3;
    localparam int unsigned BEAT_W        = 8;
    localparam int unsigned DEC_MAX_W     = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        MULTI = 2'd2
    } state_e;

    localparam logic [OPCODE_W_DEF-1:0] OP_NOP     = 4'h0;
    localparam logic [OPCODE_W_DEF-1:0] OP_LOAD    = 4'h3;
    localparam logic [OPCODE_W_DEF-1:0] OP_MUL     = 4'h8;
    localparam logic [OPCODE_W_DEF-1:0] OP_DIV     = 4'h9;
    localparam logic [OPCODE_W_DEF-1:0] OP_TRAP_LO = 4'hE;
    localparam logic [OPCODE_W_DEF-1:0] OP_TRAP_HI = 4'hF;

    // Wide one-hot; callers truncate to their control width, so out-of-range opcodes decode to zero.
    function automatic logic [DEC_MAX_W-1:0] decode_onehot(input logic [7:0] op);
        logic [DEC_MAX_W-1:0] w;
        w = '0;
        w[op] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/instr_decode_beat_ctr.sv
// Beat index and last-beat flag for one decoded instruction.
module instr_decode_beat_ctr
    import instr_decode_pkg::*;
#(
    parameter int unsigned MC_CYCLES = MC_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              multi_i,
    input  logic              adv_i,
    input  logic              clr_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              last_o
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MC_CYCLES - 1);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last_q, last_d;

    // Load wins over clear: a new opcode taken on the final handshake starts a fresh instruction.
    always_comb begin
        beat_d = beat_q;
        last_d = last_q;
        if (load_i) begin
            beat_d = '0;
            last_d = !multi_i;
        end else if (clr_i) begin
            beat_d = '0;
            last_d = 1'b0;
        end else if (adv_i && !last_q) begin
            beat_d = beat_q + BEAT_W'(1);
            last_d = (beat_d == LAST_BEAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            last_q <= 1'b0;
        end else begin
            beat_q <= beat_d;
            last_q <= last_d;
        end
    end

    assign beat_o = beat_q;
    assign last_o = last_q;

endmodule

// File: rtl/instr_decode_seq.sv
// Registered valid/ready instruction decoder emitting one-hot control beats; multi-cycle opcodes repeat.
// Optional illegal-opcode flag enabled by defining INSTR_DECODE_ILLEGAL_TRAP_EN.
module instr_decode_seq
    import instr_decode_pkg::*;
#(
    parameter int unsigned              OPCODE_W  = OPCODE_W_DEF,
    parameter int unsigned              CTRL_W    = CTRL_W_DEF,
    parameter logic [2**OPCODE_W-1:0]   MC_MASK   = MC_MASK_DEF,
    parameter int unsigned              MC_CYCLES = MC_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [BEAT_W-1:0]   out_beat,
    output logic                out_last,
    output logic                out_illegal
);

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [CTRL_W-1:0]   op_ctrl;
    logic                accept, out_hs, op_legal, op_multi;
    logic                last;

    assign out_hs   = out_valid_q & out_ready;
    assign in_ready = !out_valid_q | (out_ready & last);
    assign accept   = in_valid & in_ready;
    assign op_legal = 32'(in_opcode) < CTRL_W;
    assign op_multi = op_legal & MC_MASK[in_opcode];
    assign op_ctrl  = CTRL_W'(decode_onehot(8'(in_opcode)));

    // Drain to IDLE after the final beat unless a new opcode is captured on the same edge.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        case (state_q)
            IDLE: ;
            ISSUE, MULTI: begin
                if (out_hs && last) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    ctrl_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d     = op_multi ? MULTI : ISSUE;
            out_valid_d = 1'b1;
            ctrl_d      = op_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
        end
    end

    instr_decode_beat_ctr #(
        .MC_CYCLES (MC_CYCLES)
    ) u_beat_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .multi_i (op_multi),
        .adv_i   (out_hs),
        .clr_i   (out_hs & last),
        .beat_o  (out_beat),
        .last_o  (last)
    );

`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if (out_hs && last) illegal_d = 1'b0;
        if (accept)         illegal_d = !op_legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign out_illegal = illegal_q;
`else
    assign out_illegal = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_last  = last;

endmodule

// File: tb/tb_instr_decode_seq.sv
// Directed scoreboard bench for instr_decode_seq (default parameters).
module tb_instr_decode_seq;

    localparam logic [15:0] MASK = 16'h0300;
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    typedef struct {
        logic [13:0] ctrl;
        logic [7:0]  beat;
        logic        last;
        logic        ill;
    } exp_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_opcode;
    logic        out_valid, out_ready;
    logic [13:0] out_ctrl;
    logic [7:0]  out_beat;
    logic        out_last, out_illegal;

    int checks = 0;
    int failures = 0;
    int xfers = 0;
    exp_t exp_q[$];

    logic        stalled = 1'b0;
    logic [13:0] hold_ctrl;
    logic [7:0]  hold_beat;

    instr_decode_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_beat    (out_beat),
        .out_last    (out_last),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected beats for one opcode.
    task automatic push_exp(input logic [3:0] op);
        exp_t e;
        logic legal, multi;
        int n;
        legal = (op < 4'd14);
        multi = legal && MASK[op];
        n = multi ? 3 : 1;
        for (int b = 0; b < n; b++) begin
            e.ctrl = legal ? (14'd1 << op) : 14'd0;
            e.beat = 8'(b);
            e.last = (b == n - 1);
            e.ill  = legal ? 1'b0 : TRAP;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [3:0] op, output int waits);
        waits = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        push_exp(op);
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_opcode = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on each transfer, checks stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (stalled) begin
                check("hold_ctrl", 32'(out_ctrl), 32'(hold_ctrl));
                check("hold_beat", 32'(out_beat), 32'(hold_beat));
            end
            if (out_ready) begin
                stalled = 1'b0;
                xfers++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_ctrl), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_ctrl", 32'(out_ctrl), 32'(e.ctrl));
                    check("beat_idx", 32'(out_beat), 32'(e.beat));
                    check("beat_last", 32'(out_last), 32'(e.last));
                    check("beat_illegal", 32'(out_illegal), 32'(e.ill));
                end
            end else begin
                stalled   = 1'b1;
                hold_ctrl = out_ctrl;
                hold_beat = out_beat;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        int w, tw, xb;
        logic [4:0] pat;

        rst_n = 1'b0; in_valid = 1'b0; in_opcode = 4'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        check("rst_out_beat", 32'(out_beat), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op, first-beat latency
        send(4'h3, w);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_ctrl", 32'(out_ctrl), 32'h0008);
        check("lat_beat", 32'(out_beat), 32'd0);
        check("lat_last", 32'(out_last), 32'd1);
        drain();

        // Back-to-back single-cycle ops
        tw = 0;
        xb = xfers;
        for (int i = 0; i < 8; i++) begin
            send(4'(i), w);
            tw += w;
        end
        drain();
        check("b2b_stalls", 32'(tw), 32'd0);
        check("b2b_xfers", 32'(xfers - xb), 32'd8);

        // Multi-cycle op followed immediately by a single op (no bubble)
        send(4'h8, w);
        send(4'h2, w);
        check("mc_in_ready_stalls", 32'(w), 32'd2);
        @(negedge clk);
        check("nobubble_valid", 32'(out_valid), 32'd1);
        check("nobubble_ctrl", 32'(out_ctrl), 32'h0004);
        drain();

        // Multi-cycle op under back-pressure
        xb = xfers;
        pat = 5'b11001;
        send(4'h9, w);
        for (int i = 0; i < 5; i++) begin
            out_ready = pat[i];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        check("stall_xfers", 32'(xfers - xb), 32'd3);

        // Illegal opcodes
        send(4'hE, w);
        send(4'hF, w);
        drain();

        // Reset during beat 1 of a multi-cycle op
        send(4'h8, w);
        @(posedge clk);
        #1;
        check("pre_rst_beat", 32'(out_beat), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ctrl", 32'(out_ctrl), 32'd0);
        check("mrst_beat", 32'(out_beat), 32'd0);
        check("mrst_last", 32'(out_last), 32'd0);
        check("mrst_illegal", 32'(out_illegal), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(4'h5, w);
        drain();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
